// File: rtl/fpmul_sched_pkg.sv
// fpmul_sched_pkg
// Shared types and constants for the floating-point multiplier issue
// scheduler.
//   FPMUL_LAT : latency of the shared multiplier, operands-in to result-out
//   tag_id_t  : requester id carried down the tag pipeline (sized for up to
//               8 requesters)
//   tag_t     : one tag pipeline stage, {valid, requester id}
//   id_width  : number of bits needed to encode a requester index
package fpmul_sched_pkg;

    localparam int FPMUL_LAT = 3;
    localparam int ID_W_MAX  = 3;

    typedef logic [ID_W_MAX-1:0] tag_id_t;

    typedef struct packed {
        logic    v;
        tag_id_t id;
    } tag_t;

    // A single requester still needs a 1-bit index field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpmul_sched_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a set request
// starts at index ptr and wraps around; the first hit wins.
// Ports:
//   req    in  N    request vector
//   ptr    in  IDW  index where the search starts (must be < N)
//   gnt    out N    one-hot grant, all zero when nothing requests
//   gnt_id out IDW  encoded grant index, 0 when nothing is granted
module rr_arbiter
    import fpmul_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        idx    = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if ((gnt == '0) && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fpmul_sched.sv
// fpmul_sched
// Shares one free-running LAT-stage FP multiplier among NREQ requesters.
// A round-robin arbiter picks at most one requester per cycle, its operands
// are steered onto the multiplier inputs, and its id travels down a tag
// pipeline of the same depth so the result can be returned as a one-cycle
// pulse to the requester that issued it.
//
// Optional build macro: FPMUL_SCHED_STATS_EN adds the stat_issue and
// stat_stall counters and their ports. Without it, scheduling is identical
// and the ports do not exist.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-low reset
//   hold       in   blocks new issues; operations already issued complete
//   req_valid  in   NREQ      requester i has an operand pair
//   req_ready  out  NREQ      one-hot grant
//   req_a/b    in   NREQ*32   operands, requester i at [32i+31:32i]
//   rsp_valid  out  NREQ      one-hot result pulse
//   rsp_res    out  32        result (mul_res passthrough)
//   mul_a/b    out  32        multiplier operands, zero when idle
//   mul_res    in   32        multiplier result
//   stat_issue out  32        issue count (stats build only)
//   stat_stall out  32        cycles with a request but no issue (stats build)
//
// Handshake: an operand pair is issued in a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready may depend on req_valid in the same
// cycle, but a requester must not wait for req_ready before raising
// req_valid, and must hold req_valid and its operands until the issue.
// Responses cannot be back-pressured: rsp_valid[i] is a single-cycle pulse
// exactly LAT cycles after the issue.
module fpmul_sched
    import fpmul_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = FPMUL_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_res,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_res
`ifdef FPMUL_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_issue,
    output logic [31:0]       stat_stall
`endif
);

    localparam int IDW = id_width(NREQ);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            issue;
    tag_t            tag0_d;
    tag_t            tag_q [LAT];

    // Gating with rst keeps req_ready low while reset is asserted; the
    // first issue can happen in the first cycle with rst high.
    assign arb_req = (rst && !hold) ? req_valid : '0;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .req    (arb_req),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign issue     = |gnt;
    assign req_ready = gnt;

    // One-hot mux; zero operands when nothing is granted.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mul_a = req_a[32*i +: 32];
                mul_b = req_b[32*i +: 32];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_comb begin
        tag0_d    = '0;
        tag0_d.v  = issue;
        tag0_d.id = tag_id_t'(gnt_id);
    end

    // The multiplier never stalls, so the tag pipeline shifts every cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            tag_q[0] <= tag0_d;
            for (int s = 1; s < LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = tag_q[LAT-1].v && (tag_q[LAT-1].id == tag_id_t'(i));
        end
    end

    assign rsp_res = mul_res;

`ifdef FPMUL_SCHED_STATS_EN
    logic [31:0] stat_issue_q;
    logic [31:0] stat_stall_q;

    // A stall is any cycle with at least one request pending and no issue,
    // whether caused by hold or anything else.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_issue_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (issue) begin
                stat_issue_q <= stat_issue_q + 32'd1;
            end
            if ((|req_valid) && !issue) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_issue = stat_issue_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fpmul_sched.sv
// tb_fpmul_sched
// Bench for fpmul_sched with NREQ=4, LAT=3. A small table-driven model of the
// shared multiplier (3 register stages) feeds mul_res. Every handshake pushes
// {due cycle, requester id, expected product} onto exp_q; a negedge monitor
// pops it in the due cycle and otherwise requires rsp_valid to be zero.
// Build with +define+FPMUL_SCHED_STATS_EN to also exercise the counters.
module tb_fpmul_sched;

    localparam int NREQ = 4;

    // Known operand pairs and their single-precision products.
    localparam logic [31:0] TAB_A [8] = '{32'h3F800000, 32'h40400000, 32'h00000000, 32'h3FC00000,
                                          32'h40800000, 32'h40000000, 32'h40A00000, 32'hBF800000};
    localparam logic [31:0] TAB_B [8] = '{32'h40000000, 32'hC0000000, 32'h40490FDB, 32'h40000000,
                                          32'h3F000000, 32'h40000000, 32'h3F800000, 32'h41200000};
    localparam logic [31:0] TAB_P [8] = '{32'h40000000, 32'hC0C00000, 32'h00000000, 32'h40400000,
                                          32'h40000000, 32'h40800000, 32'h40A00000, 32'hC1200000};

    // ---------------- clock / reset / signals ----------------
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               hold = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_res;
    logic [31:0]        mul_a, mul_b, mul_res;
`ifdef FPMUL_SCHED_STATS_EN
    logic [31:0]        stat_issue, stat_stall;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fpmul_sched #(.NREQ(NREQ), .LAT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_res   (rsp_res),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_res   (mul_res)
`ifdef FPMUL_SCHED_STATS_EN
        ,
        .stat_issue(stat_issue),
        .stat_stall(stat_stall)
`endif
    );

    // ---------------- multiplier model ----------------
    function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 8; k++) begin
            if (TAB_A[k] == a && TAB_B[k] == b) return TAB_P[k];
        end
        return 32'h7FC0DEAD;
    endfunction

    logic [31:0] m_q [3];
    always @(posedge clk) begin
        m_q[0] <= fmul_model(mul_a, mul_b);
        m_q[1] <= m_q[0];
        m_q[2] <= m_q[1];
    end
    assign mul_res = m_q[2];

    // ---------------- scoreboard ----------------
    int              n_checks = 0;
    int              n_fail = 0;
    logic [71:0]     exp_q[$];
    logic [31:0]     exp_prod [NREQ];
    logic [71:0]     mon_e;
    logic [NREQ-1:0] mon_v;
    int              cnt [NREQ];

    always @(negedge clk) begin
        n_checks++;
        if (exp_q.size() > 0 && exp_q[0][71:40] == 32'(cyc)) begin
            mon_e = exp_q.pop_front();
            mon_v = '0;
            mon_v[int'(mon_e[39:32])] = 1'b1;
            if (rsp_valid !== mon_v || rsp_res !== mon_e[31:0]) begin
                n_fail++;
                $display("FAIL sb_rsp cyc %0d: got valid=%b res=%h, want valid=%b res=%h",
                         cyc, rsp_valid, rsp_res, mon_v, mon_e[31:0]);
            end
        end else if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL sb_idle cyc %0d: got rsp_valid=%b, want 0", cyc, rsp_valid);
        end
        if (rst === 1'b1) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) exp_q.push_back({32'(cyc + 3), 8'(i), exp_prod[i]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int k);
        req_a[32*i +: 32] = TAB_A[k];
        req_b[32*i +: 32] = TAB_B[k];
        exp_prod[i]       = TAB_P[k];
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0; hold = 1'b0; req_valid = '0;
        tick();
        exp_q.delete();
        tick();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    endtask

    // Requester i keeps req_valid high while it has operations left.
    task automatic drive_from_cnt();
        for (int i = 0; i < NREQ; i++) req_valid[i] = (cnt[i] > 0);
    endtask

    task automatic retire_hs();
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) cnt[i]--;
        end
    endtask

    task automatic drain(input int n);
        req_valid = '0; hold = 1'b0;
        repeat (n) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; hold = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 3);
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (req_ready !== '0 || rsp_valid !== '0 || mul_a !== '0 || mul_b !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got ready=%b rsp=%b a=%h b=%h, want all 0",
                         req_ready, rsp_valid, mul_a, mul_b);
            end
`ifdef FPMUL_SCHED_STATS_EN
            n_checks++;
            if (stat_issue !== 32'd0 || stat_stall !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_stats: got issue=%0d stall=%0d, want 0 0", stat_issue, stat_stall);
            end
`endif
        end
        req_valid = '0;
    endtask

    task automatic test_single_issue();
        do_reset();
        set_op(1, 0);
        for (int c = 0; c < 6; c++) begin
            req_valid = (c == 0) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (req_ready !== 4'b0010 || mul_a !== 32'h3F800000 || mul_b !== 32'h40000000) begin
                    n_fail++;
                    $display("FAIL single_issue: got ready=%b a=%h b=%h, want 0010 3f800000 40000000",
                             req_ready, mul_a, mul_b);
                end
            end
            if (c == 1) begin
                n_checks++;
                if (mul_a !== 32'h0 || mul_b !== 32'h0) begin
                    n_fail++;
                    $display("FAIL single_idle_ops: got a=%h b=%h, want 0 0", mul_a, mul_b);
                end
            end
            n_checks++;
            if (rsp_valid !== ((c == 3) ? 4'b0010 : 4'b0000)) begin
                n_fail++;
                $display("FAIL single_rsp c%0d: got %b", c, rsp_valid);
            end
            if (c == 3) begin
                n_checks++;
                if (rsp_res !== 32'h40000000) begin
                    n_fail++;
                    $display("FAIL single_res: got %h want 40000000", rsp_res);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        set_op(0, 3); set_op(1, 0); set_op(2, 1); set_op(3, 7);
        cnt[0] = 2; cnt[1] = 1; cnt[2] = 1; cnt[3] = 1;
        for (int c = 0; c < 9; c++) begin
            drive_from_cnt();
            @(negedge clk);
            if (c < 5) begin
                n_checks++;
                if (req_ready !== (4'(1) << (c % 4))) begin
                    n_fail++;
                    $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, 4'(1) << (c % 4));
                end
            end
            if (c >= 3 && c <= 7) begin
                n_checks++;
                if (rsp_valid !== (4'(1) << ((c - 3) % 4))) begin
                    n_fail++;
                    $display("FAIL rr_rsp c%0d: got %b want %b", c, rsp_valid, 4'(1) << ((c - 3) % 4));
                end
            end
            if (c == 5) begin
                n_checks++;
                if (rsp_res !== 32'hC0C00000) begin
                    n_fail++;
                    $display("FAIL rr_res2: got %h want c0c00000", rsp_res);
                end
            end
            retire_hs();
            tick();
        end
        drain(2);
    endtask

    task automatic test_zero_operand();
        do_reset();
        set_op(1, 5); set_op(0, 2);
        for (int c = 0; c < 6; c++) begin
            req_valid = (c == 0) ? 4'b0010 : (c == 1) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (c == 4) begin
                n_checks++;
                if (rsp_valid !== 4'b0001 || rsp_res !== 32'h00000000) begin
                    n_fail++;
                    $display("FAIL zero_res: got valid=%b res=%h want 0001 00000000", rsp_valid, rsp_res);
                end
            end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [3:0] g_tab [8];
        g_tab = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0010};
        do_reset();
        set_op(0, 3); set_op(1, 0); set_op(2, 1);
        cnt[0] = 2; cnt[1] = 2; cnt[2] = 1;
        for (int c = 0; c < 12; c++) begin
            drive_from_cnt();
            hold = (c >= 2 && c <= 4);
            @(negedge clk);
            if (c < 8) begin
                n_checks++;
                if (req_ready !== g_tab[c]) begin
                    n_fail++;
                    $display("FAIL hold_grant c%0d: got %b want %b", c, req_ready, g_tab[c]);
                end
            end
            if (c == 4 || c == 8) begin
                n_checks++;
                if (rsp_valid !== ((c == 4) ? 4'b0010 : 4'b0100)) begin
                    n_fail++;
                    $display("FAIL hold_rsp c%0d: got %b", c, rsp_valid);
                end
            end
`ifdef FPMUL_SCHED_STATS_EN
            if (c == 5) begin
                n_checks++;
                if (stat_issue !== 32'd2 || stat_stall !== 32'd3) begin
                    n_fail++;
                    $display("FAIL hold_stats: got issue=%0d stall=%0d want 2 3", stat_issue, stat_stall);
                end
            end
`endif
            retire_hs();
            tick();
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            req_valid = '0;
            rst = (c == 2) ? 1'b0 : 1'b1;
            if (c == 0) begin set_op(1, 0); req_valid = 4'b0010; end
            if (c == 1) begin set_op(2, 1); req_valid = 4'b0100; end
            if (c == 2) exp_q.delete();
            if (c == 7) begin set_op(1, 5); set_op(3, 6); req_valid = 4'b1010; end
            if (c == 8) req_valid = 4'b1000;
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                n_checks++;
                if (rsp_valid !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL midrst_rsp c%0d: got %b want 0000", c, rsp_valid);
                end
            end
            if (c == 7 || c == 8) begin
                n_checks++;
                if (req_ready !== ((c == 7) ? 4'b0010 : 4'b1000)) begin
                    n_fail++;
                    $display("FAIL midrst_ptr c%0d: got %b", c, req_ready);
                end
            end
            tick();
        end
        drain(5);
    endtask

    task automatic test_back_to_back();
        int ops [4];
        ops = '{7, 6, 5, 3};
        do_reset();
        cnt[3] = 4;
        for (int c = 0; c < 8; c++) begin
            if (cnt[3] > 0) set_op(3, ops[4 - cnt[3]]);
            drive_from_cnt();
            @(negedge clk);
            if (c < 4) begin
                n_checks++;
                if (req_ready !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL b2b_grant c%0d: got %b want 1000", c, req_ready);
                end
            end
            if (c >= 3 && c <= 6) begin
                n_checks++;
                if (rsp_valid !== 4'b1000 || rsp_res !== TAB_P[ops[c - 3]]) begin
                    n_fail++;
                    $display("FAIL b2b_rsp c%0d: got %b %h want 1000 %h", c, rsp_valid, rsp_res, TAB_P[ops[c - 3]]);
                end
            end
            retire_hs();
            tick();
        end
    endtask

    task automatic test_random();
        int              m_ptr;
        int              gi;
        int              idx;
        logic [NREQ-1:0] exp_g;
        do_reset();
        m_ptr = 0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (cnt[i] == 0 && $urandom_range(0, 2) != 0) begin
                    set_op(i, int'($urandom_range(0, 7)));
                    cnt[i] = 1;
                end
            end
            drive_from_cnt();
            hold = ($urandom_range(0, 6) == 0);
            @(negedge clk);
            exp_g = '0;
            gi = 0;
            if (!hold) begin
                for (int off = 0; off < NREQ; off++) begin
                    idx = (m_ptr + off) % NREQ;
                    if (req_valid[idx] && exp_g == '0) begin
                        exp_g[idx] = 1'b1;
                        gi = idx;
                    end
                end
            end
            n_checks++;
            if (req_ready !== exp_g) begin
                n_fail++;
                $display("FAIL rand_grant c%0d: got %b want %b (valid=%b hold=%b)", c, req_ready, exp_g, req_valid, hold);
            end
            if (exp_g != '0) m_ptr = (gi + 1) % NREQ;
            retire_hs();
            tick();
        end
        drain(5);
    endtask

`ifdef FPMUL_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        set_op(0, 3);
        cnt[0] = 10;
        for (int c = 0; c < 14; c++) begin
            drive_from_cnt();
            hold = (c < 3);
            @(negedge clk);
            if (c == 13) begin
                n_checks++;
                if (stat_issue !== 32'd10 || stat_stall !== 32'd3) begin
                    n_fail++;
                    $display("FAIL stats_count: got issue=%0d stall=%0d want 10 3", stat_issue, stat_stall);
                end
            end
            retire_hs();
            tick();
        end
        drain(4);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < NREQ; i++) begin
            exp_prod[i] = '0;
            cnt[i] = 0;
        end
        test_reset();
        test_single_issue();
        test_round_robin();
        test_zero_operand();
        test_hold();
        test_reset_midflight();
        test_back_to_back();
        test_random();
`ifdef FPMUL_SCHED_STATS_EN
        test_stats();
`endif
        drain(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d responses outstanding, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
